intan_spi_responder: RTL and testbench



---
 rtl/intan_spi_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_intan_spi_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/intan_spi_responder.sv
// Purpose : SPI slave emulating the RHD2000 headstage command link (16-bit frames, 2-deep result pipeline).
// Latency : pin-to-action 3 bus_clk (2 sync + 1 edge detect); frame_valid/frame_error 4 bus_clk after CS rise.
// Backpr. : none; the SPI master sets the pace, so SCLK phases must be >= 4 bus_clk and CS high >= 3 bus_clk.
//
// Ports:
//   bus_clk     in   system clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   SCLK        in   SPI clock from master (asynchronous, synchronized here)
//   CS          in   active-low chip select (asynchronous, synchronized here)
//   MOSI        in   command bit (asynchronous, synchronized here)
//   MISO        out  registered result bit
//   frame_valid out  one-cycle pulse: a complete 16-bit frame was executed
//   frame_cmd   out  last executed command word, held until the next frame_valid
//   frame_error out  one-cycle pulse: CS rose with a bit count other than 16
module intan_spi_responder #(
    parameter logic [7:0] CHIP_ID   = 8'd2,
    parameter int         NUM_WREGS = 22
) (
    input  logic        bus_clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        frame_valid,
    output logic [15:0] frame_cmd,
    output logic        frame_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_cs_s1,   r_cs_s2,   r_cs_d;
    logic r_mosi_s1, r_mosi_s2;

    // The CS chain resets to 0 (as if selected): a frame already in progress
    // when reset releases produces no falling edge and is therefore ignored,
    // while an idle-high CS only yields a rising edge that IDLE discards.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
            r_cs_d    <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= CS;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_d;
    assign w_cs_rise   =  r_cs_s2   & ~r_cs_d;
    assign w_cs_fall   = ~r_cs_s2   &  r_cs_d;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t r_state, w_state_nxt;
    logic   r_fall_pend;     // CS fall seen while in EXEC, serviced from IDLE
    logic   w_start;         // load transmit word and begin a frame
    logic   w_exec;          // single execute cycle after CS rise

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall || r_fall_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fall_pend <= 1'b0;
        end else if (w_exec && w_cs_fall) begin
            r_fall_pend <= 1'b1;
        end else if (w_start) begin
            r_fall_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shift registers and result pipeline
    // ------------------------------------------------------------------
    logic [15:0] r_rx_sr;
    logic [15:0] r_tx_sr;
    logic [4:0]  r_bit_cnt;
    logic        r_miso;
    logic [15:0] r_res_q1;
    logic [15:0] r_res_q2;
    logic [9:0]  r_frame_cnt;
    logic [15:0] r_frame_cmd;
    logic        r_frame_valid;
    logic        r_frame_error;
    logic [7:0]  r_regs [NUM_WREGS];

    // Command fields
    logic [1:0]  w_op;
    logic [5:0]  w_addr;
    logic [7:0]  w_wdat;
    logic        w_frame_ok;
    logic        w_in_rf;
    logic [7:0]  w_rd_val;
    logic [15:0] w_result;

    assign w_op       = r_rx_sr[15:14];
    assign w_addr     = r_rx_sr[13:8];
    assign w_wdat     = r_rx_sr[7:0];
    assign w_frame_ok = (r_bit_cnt == 5'd16);

    // Read mux: writable file first, then the "INTAN" ROM and the chip ID.
    always_comb begin
        w_in_rf  = 1'b0;
        w_rd_val = 8'h00;
        for (int i = 0; i < NUM_WREGS; i++) begin
            if (w_addr == 6'(i)) begin
                w_in_rf  = 1'b1;
                w_rd_val = r_regs[i];
            end
        end
        if (!w_in_rf) begin
            case (w_addr)
                6'd40:   w_rd_val = 8'h49;
                6'd41:   w_rd_val = 8'h4E;
                6'd42:   w_rd_val = 8'h54;
                6'd43:   w_rd_val = 8'h41;
                6'd44:   w_rd_val = 8'h4E;
                6'd63:   w_rd_val = CHIP_ID;
                default: w_rd_val = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_result = 16'h0000;
        case (w_op)
            2'b00: w_result = {r_frame_cnt, w_addr};
            2'b01: w_result = ((r_rx_sr == 16'h5500) || (r_rx_sr == 16'h6A00)) ? 16'h8000 : 16'h0000;
            2'b10: w_result = {8'hFF, w_wdat};
            2'b11: w_result = {8'h00, w_rd_val};
            default: w_result = 16'h0000;
        endcase
    end

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sr       <= 16'h0000;
            r_tx_sr       <= 16'h0000;
            r_bit_cnt     <= 5'd0;
            r_miso        <= 1'b0;
            r_res_q1      <= 16'h0000;
            r_res_q2      <= 16'h0000;
            r_frame_cnt   <= 10'd0;
            r_frame_cmd   <= 16'h0000;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_start) begin
                // The oldest pipeline result goes out MSB first in this frame.
                r_tx_sr   <= r_res_q2;
                r_miso    <= r_res_q2[15];
                r_bit_cnt <= 5'd0;
            end else if (r_state == ST_SHIFT) begin
                if (w_cs_rise) begin
                    r_miso <= 1'b0;
                end else begin
                    if (w_sclk_rise) begin
                        r_rx_sr <= {r_rx_sr[14:0], r_mosi_s2};
                        if (r_bit_cnt != 5'd31) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    if (w_sclk_fall) begin
                        // Zero fill drives MISO low once all 16 bits are out.
                        r_tx_sr <= {r_tx_sr[14:0], 1'b0};
                        r_miso  <= r_tx_sr[14];
                    end
                end
            end else if (w_exec) begin
                if (w_frame_ok) begin
                    r_res_q2      <= r_res_q1;
                    r_res_q1      <= w_result;
                    r_frame_cmd   <= r_rx_sr;
                    r_frame_valid <= 1'b1;
                    if ((w_op == 2'b00) && (w_addr == 6'd0)) begin
                        r_frame_cnt <= r_frame_cnt + 10'd1;
                    end
                end else begin
                    r_frame_error <= 1'b1;
                end
            end
        end
    end

    // Writable register file: only addresses below NUM_WREGS exist.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_exec && w_frame_ok && (w_op == 2'b10)) begin
            for (int i = 0; i < NUM_WREGS; i++) begin
                if (w_addr == 6'(i)) begin
                    r_regs[i] <= w_wdat;
                end
            end
        end
    end

    assign MISO        = r_miso;
    assign frame_valid = r_frame_valid;
    assign frame_cmd   = r_frame_cmd;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_intan_spi_responder.sv
// Bench for intan_spi_responder: directed SPI frames with hand-computed
// expected MISO words and frame_cmd values, checked by a scoreboard monitor
// that pops one expectation per frame_valid / frame_error pulse.
module tb_intan_spi_responder;

    logic        bus_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        SCLK    = 1'b0;
    logic        CS      = 1'b1;
    logic        MOSI    = 1'b0;
    logic        MISO;
    logic        frame_valid;
    logic        frame_error;
    logic [15:0] frame_cmd;

    intan_spi_responder #(
        .CHIP_ID   (8'd2),
        .NUM_WREGS (22)
    ) dut (
        .bus_clk     (bus_clk),
        .reset_n     (reset_n),
        .SCLK        (SCLK),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_error (frame_error)
    );

    always #2 bus_clk = ~bus_clk;

    typedef struct {
        bit          is_err;
        logic [15:0] cmd;
        logic [15:0] miso;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] cap_word = 16'h0000;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge bus_clk);
    endtask

    // Mode-0 style bit clocking; MISO is sampled just before each SCLK rise.
    task automatic spi_bits(input logic [15:0] cmd, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int k;
            k = 15 - i;
            MOSI = (k >= 0) ? cmd[k] : 1'b0;
            clk_n(8);
            if (k >= 0) cap_word[k] = MISO;
            SCLK = 1'b1;
            clk_n(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [15:0] cmd, input int nbits);
        CS = 1'b0;
        clk_n(8);
        spi_bits(cmd, nbits);
        clk_n(8);
        CS = 1'b1;
        clk_n(12);
    endtask

    task automatic frame(input string name, input logic [15:0] cmd, input logic [15:0] exp_miso);
        sb.push_back('{is_err: 1'b0, cmd: cmd, miso: exp_miso, name: name});
        run_frame(cmd, 16);
        check16({name, "_miso_idle"}, {15'd0, MISO}, 16'h0000);
    endtask

    task automatic bad_frame(input string name, input logic [15:0] cmd, input int nbits,
                             input logic [15:0] held_cmd);
        sb.push_back('{is_err: 1'b1, cmd: held_cmd, miso: 16'h0000, name: name});
        run_frame(cmd, nbits);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge bus_clk);
            if (reset_n && (frame_valid || frame_error)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event valid=%b error=%b cmd=%h required=no event",
                             frame_valid, frame_error, frame_cmd);
                end else begin
                    e = sb.pop_front();
                    check16({e.name, "_is_error"}, {15'd0, frame_error}, {15'd0, e.is_err});
                    check16({e.name, "_cmd"}, frame_cmd, e.cmd);
                    if (!e.is_err) check16({e.name, "_miso_word"}, cap_word, e.miso);
                end
            end
        end
    end

    // Global time limit
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        // Reset behaviour with pins toggling
        clk_n(3);
        check16("rst_miso",  {15'd0, MISO}, 16'h0000);
        check16("rst_valid", {15'd0, frame_valid}, 16'h0000);
        check16("rst_error", {15'd0, frame_error}, 16'h0000);
        check16("rst_cmd",   frame_cmd, 16'h0000);
        CS = 1'b0; SCLK = 1'b1; MOSI = 1'b1;
        clk_n(6);
        SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        clk_n(6);
        check16("rst_tog_miso",  {15'd0, MISO}, 16'h0000);
        check16("rst_tog_valid", {15'd0, frame_valid}, 16'h0000);
        check16("rst_tog_error", {15'd0, frame_error}, 16'h0000);
        check16("rst_tog_cmd",   frame_cmd, 16'h0000);
        reset_n = 1'b1;
        clk_n(10);

        // Pipeline / read-after-write
        frame("p_wr5",   16'h85A3, 16'h0000);
        frame("p_rd5",   16'hC500, 16'h0000);
        frame("p_rd40",  16'hE800, 16'hFFA3);
        frame("p_d1",    16'hFF00, 16'h00A3);
        frame("p_d2",    16'hFF00, 16'h0049);
        // Chip ID and ROM
        frame("id_d0",   16'hFF00, 16'h0002);
        frame("id_rd44", 16'hEC00, 16'h0002);
        frame("id_d1",   16'hFF00, 16'h0002);
        frame("id_d2",   16'hFF00, 16'h004E);
        // CONVERT with frame counter
        frame("cv_ch0a", 16'h0000, 16'h0002);
        frame("cv_ch5a", 16'h0500, 16'h0002);
        frame("cv_ch0b", 16'h0000, 16'h0000);
        frame("cv_ch5b", 16'h0500, 16'h0045);
        frame("cv_d1",   16'hFF00, 16'h0040);
        frame("cv_d2",   16'hFF00, 16'h0085);
        // CALIBRATE / CLEAR / other 01, write boundary, unmapped read
        frame("calib",   16'h5500, 16'h0002);
        frame("clear",   16'h6A00, 16'h0002);
        frame("op01",    16'h4123, 16'h8000);
        frame("wr21",    16'h9577, 16'h8000);
        frame("wr22",    16'h965A, 16'h0000);
        frame("rd21",    16'hD500, 16'hFF77);
        frame("rd22",    16'hD600, 16'hFF5A);
        frame("rd30",    16'hDE00, 16'h0077);
        frame("rd42",    16'hEA00, 16'h0000);
        frame("rd5b",    16'hC500, 16'h0000);
        // Truncated and over-long frames leave pipeline and frame_cmd alone
        bad_frame("trunc9", 16'h8DEE, 9, 16'hC500);
        frame("tr_d1",   16'hFF00, 16'h0054);
        frame("tr_d2",   16'hFF00, 16'h00A3);
        bad_frame("long17", 16'hFF00, 17, 16'hFF00);
        frame("lg_d1",   16'hFF00, 16'h0002);

        // Reset in the middle of a WRITE; the rest of that frame is ignored
        CS = 1'b0;
        clk_n(8);
        spi_bits(16'h85A3, 7);
        reset_n = 1'b0;
        clk_n(4);
        check16("mid_rst_cmd",  frame_cmd, 16'h0000);
        check16("mid_rst_miso", {15'd0, MISO}, 16'h0000);
        reset_n = 1'b1;
        clk_n(4);
        spi_bits(16'h4600, 9);
        clk_n(8);
        CS = 1'b1;
        clk_n(20);
        check16("mid_rst_cmd_after", frame_cmd, 16'h0000);
        frame("mr_rd5",  16'hC500, 16'h0000);
        frame("mr_d1",   16'hFF00, 16'h0000);
        frame("mr_d2",   16'hFF00, 16'h0000);
        frame("mr_d3",   16'hFF00, 16'h0002);

        clk_n(50);
        check16("sb_drained", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
